// File: rtl/config_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : config_frame_writer
//  Description : Writer side of a column frame-latch configuration interface.
//                Arms on a sync word, decodes frame headers, assembles one
//                frame word per row, then presents FrameData and pulses a
//                single FrameStrobe bit with setup and hold cycles around it.
//  Revision    : 1.0  initial release
// ============================================================================
module config_frame_writer #(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumRows         = 4,
  parameter int          StrobeWidth     = 2,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                               CLK,
  input  logic                               resetn,
  input  logic [FrameBitsPerRow-1:0]         WriteData,
  input  logic                               WriteStrobe,
  output logic                               WriteReady,
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               Busy,
  output logic                               Error,
  output logic [7:0]                         FramesDone
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int CntW = $clog2(StrobeWidth + 1);

  localparam logic [7:0] OpFrame = 8'hF0;
  localparam logic [7:0] OpEnd   = 8'h00;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    LOAD   = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5
  } state_t;

  state_t                state;
  logic [RowW-1:0]       row;
  logic [CntW-1:0]       strobe_cnt;
  logic [7:0]            frame_index;
  logic                  index_valid;
  logic [MaxFramesPerCol-1:0] strobe_sel;
  logic                  accept;

  assign accept = WriteStrobe & WriteReady;

  // One-hot decode of the current frame index; all zeros for an out-of-range index
  always_comb begin
    strobe_sel = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      strobe_sel[i] = index_valid && (frame_index == 8'(i));
    end
  end

  // Frame writer sequencer; every output is registered and set on the transition into its state
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      row         <= '0;
      strobe_cnt  <= '0;
      frame_index <= '0;
      index_valid <= 1'b0;
      WriteReady  <= 1'b1;
      FrameData   <= '0;
      FrameStrobe <= '0;
      Busy        <= 1'b0;
      Error       <= 1'b0;
      FramesDone  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (WriteData == SyncWord)) begin
            state      <= HEADER;
            Busy       <= 1'b1;
            Error      <= 1'b0;
            FramesDone <= '0;
          end
        end
        HEADER: begin
          if (accept) begin
            if (WriteData[31:24] == OpFrame) begin
              frame_index <= WriteData[7:0];
              index_valid <= (WriteData[7:0] < 8'(MaxFramesPerCol));
              if (WriteData[7:0] >= 8'(MaxFramesPerCol)) begin
                Error <= 1'b1;
              end
              row   <= '0;
              state <= LOAD;
            end else if (WriteData[31:24] == OpEnd) begin
              state <= IDLE;
              Busy  <= 1'b0;
            end else begin
              // Unknown opcode, including a repeated sync word, aborts the stream
              Error <= 1'b1;
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            FrameData[row*FrameBitsPerRow +: FrameBitsPerRow] <= WriteData;
            if (row == RowW'(NumRows - 1)) begin
              state      <= SETUP;
              WriteReady <= 1'b0;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        SETUP: begin
          // FrameData has been stable for this cycle; raise the enable next
          state       <= STROBE;
          strobe_cnt  <= '0;
          FrameStrobe <= strobe_sel;
        end
        STROBE: begin
          if (strobe_cnt == CntW'(StrobeWidth - 1)) begin
            state       <= HOLD;
            FrameStrobe <= '0;
          end else begin
            strobe_cnt <= strobe_cnt + 1'b1;
          end
        end
        HOLD: begin
          state      <= HEADER;
          WriteReady <= 1'b1;
          if (index_valid) begin
            FramesDone <= FramesDone + 8'd1;
          end
        end
        default: begin
          state       <= IDLE;
          WriteReady  <= 1'b1;
          FrameStrobe <= '0;
          Busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_config_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_config_frame_writer
//  Description : Directed self-checking bench for config_frame_writer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_config_frame_writer;

  logic         CLK;
  logic         resetn;
  logic [31:0]  WriteData;
  logic         WriteStrobe;
  logic         WriteReady;
  logic [127:0] FrameData;
  logic [19:0]  FrameStrobe;
  logic         Busy;
  logic         Error;
  logic [7:0]   FramesDone;

  int errors = 0;
  int checks = 0;

  config_frame_writer dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .WriteData   (WriteData),
    .WriteStrobe (WriteStrobe),
    .WriteReady  (WriteReady),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .Busy        (Busy),
    .Error       (Error),
    .FramesDone  (FramesDone)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one word and return just after the edge that accepts it
  task automatic send(input logic [31:0] w);
    int n = 0;
    @(negedge CLK);
    WriteData   = w;
    WriteStrobe = 1'b1;
    while (!WriteReady && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      chk("send_timeout", 128'(n), 128'd0);
    end
    @(posedge CLK);
    #1 WriteStrobe = 1'b0;
  endtask

  // Walk the five cycles after the last row: SETUP, STROBE x2, HOLD, back in HEADER
  task automatic gap(input string tag, input logic [19:0] exp_strobe, input logic hold_strobe);
    if (hold_strobe) begin
      WriteData   = 32'h9999_9999;
      WriteStrobe = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (k == 4) WriteStrobe = 1'b0;
      chk({tag, "_ready"}, 128'(WriteReady), 128'(k == 4));
      chk({tag, "_strobe"}, 128'(FrameStrobe), (k == 1 || k == 2) ? 128'(exp_strobe) : 128'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 128'(WriteReady), 128'd1);
    chk({tag, "_data"}, FrameData, 128'd0);
    chk({tag, "_strobe"}, 128'(FrameStrobe), 128'd0);
    chk({tag, "_busy"}, 128'(Busy), 128'd0);
    chk({tag, "_error"}, 128'(Error), 128'd0);
    chk({tag, "_done"}, 128'(FramesDone), 128'd0);
  endtask

  logic [127:0] exp_data;

  initial begin
    resetn      = 1'b0;
    WriteData   = '0;
    WriteStrobe = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // Words before the sync word are dropped
    send(32'hDEAD_BEEF);
    send(32'hF000_0001);
    repeat (3) @(negedge CLK);
    chk("presync_busy", 128'(Busy), 128'd0);
    chk("presync_strobe", 128'(FrameStrobe), 128'd0);
    chk("presync_data", FrameData, 128'd0);

    // Basic frame to index 3, with WriteStrobe held through the gap
    send(32'hFAB0_FAB1);
    chk("sync_busy", 128'(Busy), 128'd1);
    send(32'hF000_0003);
    send(32'h1111_1111);
    send(32'h2222_2222);
    send(32'h3333_3333);
    send(32'h4444_4444);
    gap("frame3", 20'h00008, 1'b1);
    chk("frame3_data", FrameData, 128'h44444444_33333333_22222222_11111111);
    chk("frame3_done", 128'(FramesDone), 128'd1);
    chk("frame3_busy", 128'(Busy), 128'd1);

    // Out-of-range index: loaded, no strobe, error, back to HEADER
    send(32'hF000_0015);
    chk("badidx_error", 128'(Error), 128'd1);
    send(32'h5555_5555);
    send(32'h6666_6666);
    send(32'h7777_7777);
    send(32'h8888_8888);
    gap("badidx", 20'h00000, 1'b0);
    chk("badidx_data", FrameData, 128'h88888888_77777777_66666666_55555555);
    chk("badidx_done", 128'(FramesDone), 128'd1);
    chk("badidx_busy", 128'(Busy), 128'd1);
    send(32'h0000_0000);
    @(negedge CLK);
    chk("end_busy", 128'(Busy), 128'd0);
    chk("end_error_sticky", 128'(Error), 128'd1);

    // Sync clears error and count; bad opcode returns to IDLE with error
    send(32'hFAB0_FAB1);
    chk("resync_error", 128'(Error), 128'd0);
    chk("resync_done", 128'(FramesDone), 128'd0);
    send(32'h7A00_0000);
    chk("badop_error", 128'(Error), 128'd1);
    chk("badop_busy", 128'(Busy), 128'd0);

    // Sync word inside HEADER counts as an invalid opcode
    send(32'hFAB0_FAB1);
    send(32'hFAB0_FAB1);
    chk("synchdr_error", 128'(Error), 128'd1);
    chk("synchdr_busy", 128'(Busy), 128'd0);

    // Twenty frames back to back, one per strobe line
    send(32'hFAB0_FAB1);
    chk("frames_error", 128'(Error), 128'd0);
    for (int i = 0; i < 20; i++) begin
      send({24'hF00000, 8'(i)});
      for (int r = 0; r < 4; r++) begin
        send({8'(i), 8'(r), 16'hA5A5});
      end
      gap($sformatf("frame%0d", i), 20'(1) << i, 1'b0);
    end
    chk("frames_done", 128'(FramesDone), 128'd20);
    exp_data = {32'h1303A5A5, 32'h1302A5A5, 32'h1301A5A5, 32'h1300A5A5};
    chk("frames_data", FrameData, exp_data);
    send(32'h0000_0000);

    // Reset asserted while the strobe is high
    send(32'hFAB0_FAB1);
    send(32'hF000_0002);
    send(32'hAAAA_0000);
    send(32'hAAAA_0001);
    send(32'hAAAA_0002);
    send(32'hAAAA_0003);
    @(negedge CLK);
    @(negedge CLK);
    chk("midrst_strobe_before", 128'(FrameStrobe), 128'h4);
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge CLK);
    resetn = 1'b1;

    // Restart; sync word inside LOAD is plain data
    send(32'hFAB0_FAB1);
    send(32'hF000_0005);
    send(32'hFAB0_FAB1);
    send(32'h0BAD_0001);
    send(32'h0BAD_0002);
    send(32'h0BAD_0003);
    gap("restart", 20'h00020, 1'b0);
    chk("restart_data", FrameData, 128'h0BAD0003_0BAD0002_0BAD0001_FAB0FAB1);
    chk("restart_done", 128'(FramesDone), 128'd1);
    chk("restart_error", 128'(Error), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
